// File: rtl/fc_pkg.sv
// Shared definitions for the streaming fully connected layer: FSM encoding,
// width helpers and the round/saturate/ReLU output stage.
package fc_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator wide enough for INPUT_NUM full-scale products plus sign.
    function automatic int acc_w(input int dw, input int wb, input int n);
        return dw + wb + clog2(n) + 1;
    endfunction

    // Round half up, arithmetic shift, clamp to a dw-bit signed range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] s,
                                                     input int shift,
                                                     input int dw,
                                                     input logic relu);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (s + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        if (relu && (r < 0)) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// LANES signed multipliers with registered products and a lane adder.
// The sum is combinational from the product registers.
module fc_mac_lanes
    import fc_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int W_BITS = 8,
    parameter int LANES  = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [LANES*DATA_W-1:0]                        a,
    input  logic [LANES*W_BITS-1:0]                        w,
    output logic signed [DATA_W+W_BITS+clog2(LANES)-1:0]   sum
);

    localparam int PROD_W = DATA_W + W_BITS;
    localparam int SUM_W  = PROD_W + clog2(LANES);

    logic signed [PROD_W-1:0] prod_c [LANES];
    logic signed [PROD_W-1:0] prod   [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_c[l] = PROD_W'($signed(a[l*DATA_W +: DATA_W]))
                      * PROD_W'($signed(w[l*W_BITS +: W_BITS]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) prod[l] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) prod[l] <= prod_c[l];
        end
    end

    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            sum = sum + SUM_W'(prod[l]);
        end
    end

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully connected layer: buffers one input vector, computes
// OUTPUT_NUM dot products LANES at a time, emits rounded results and argmax.
module fc_layer_stream
    import fc_pkg::*;
#(
    parameter int INPUT_NUM  = 48,
    parameter int OUTPUT_NUM = 10,
    parameter int IN_CH      = 3,
    parameter int DATA_W     = 12,
    parameter int W_BITS     = 8,
    parameter int LANES      = 8,
    parameter int OUT_SHIFT  = 7,
    parameter int RELU_EN    = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [IN_CH*DATA_W-1:0]                   in_data,
    input  logic [0:INPUT_NUM*OUTPUT_NUM*W_BITS-1]    w_fc,
    input  logic [0:OUTPUT_NUM*W_BITS-1]              b_fc,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic signed [DATA_W-1:0]                  out_data,
    output logic [clog2(OUTPUT_NUM)-1:0]              out_idx,
    output logic                                      out_last,
    output logic                                      argmax_valid,
    output logic [clog2(OUTPUT_NUM)-1:0]              argmax_idx,
    output logic                                      busy
);

    localparam int BEATS  = INPUT_NUM / IN_CH;
    localparam int K      = INPUT_NUM / LANES;
    localparam int IDX_W  = clog2(OUTPUT_NUM);
    localparam int BW     = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
    localparam int KW     = (clog2(K) > 0) ? clog2(K) : 1;
    localparam int BUF_AW = (clog2(INPUT_NUM) > 0) ? clog2(INPUT_NUM) : 1;
    localparam int WSEL_W = clog2(INPUT_NUM * OUTPUT_NUM * W_BITS);
    localparam int BSEL_W = (clog2(OUTPUT_NUM * W_BITS) > 0) ? clog2(OUTPUT_NUM * W_BITS) : 1;
    localparam int ACC_W  = acc_w(DATA_W, W_BITS, INPUT_NUM);
    localparam int SUM_W  = DATA_W + W_BITS + clog2(LANES);

    logic [1:0]                state;
    logic [BW-1:0]             beat;
    logic [KW-1:0]             mac_cnt;
    logic                      flush_cnt;
    logic [IDX_W-1:0]          o;
    logic                      mac_d;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  max_val;
    logic [IDX_W-1:0]          max_idx;

    logic signed [DATA_W-1:0]  buffer [INPUT_NUM];

    logic [LANES*DATA_W-1:0]   lane_a;
    logic [LANES*W_BITS-1:0]   lane_w;
    logic signed [SUM_W-1:0]   lane_sum;
    logic signed [ACC_W:0]     s_full;
    logic signed [DATA_W-1:0]  result;

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state != ST_LOAD);

    // Buffer holds data only; a reset simply makes the next frame overwrite it.
    always_ff @(posedge clk) begin
        if ((state == ST_LOAD) && in_valid) begin
            for (int c = 0; c < IN_CH; c++) begin
                buffer[BUF_AW'(c*BEATS + int'(beat))] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        lane_a = '0;
        lane_w = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_a[l*DATA_W +: DATA_W] = buffer[BUF_AW'(int'(mac_cnt)*LANES + l)];
            lane_w[l*W_BITS +: W_BITS] =
                w_fc[WSEL_W'((int'(o)*INPUT_NUM + int'(mac_cnt)*LANES + l)*W_BITS) +: W_BITS];
        end
    end

    fc_mac_lanes #(
        .DATA_W (DATA_W),
        .W_BITS (W_BITS),
        .LANES  (LANES)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .a   (lane_a),
        .w   (lane_w),
        .sum (lane_sum)
    );

    assign s_full = (ACC_W+1)'(acc)
                  + (ACC_W+1)'($signed(b_fc[BSEL_W'(int'(o)*W_BITS) +: W_BITS]));
    assign result = DATA_W'(round_sat(64'(s_full), OUT_SHIFT, DATA_W, RELU_EN != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_LOAD;
            beat         <= '0;
            mac_cnt      <= '0;
            flush_cnt    <= 1'b0;
            o            <= '0;
            mac_d        <= 1'b0;
            acc          <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            out_last     <= 1'b0;
            argmax_valid <= 1'b0;
            argmax_idx   <= '0;
            max_val      <= '0;
            max_idx      <= '0;
        end else begin
            argmax_valid <= 1'b0;
            // Products land one cycle after issue, so accumulate one cycle behind MAC.
            mac_d <= (state == ST_MAC);
            if (mac_d) acc <= acc + ACC_W'(lane_sum);

            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (beat == BW'(BEATS - 1)) begin
                            beat    <= '0;
                            o       <= '0;
                            acc     <= '0;
                            mac_cnt <= '0;
                            state   <= ST_MAC;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (mac_cnt == KW'(K - 1)) begin
                        mac_cnt   <= '0;
                        flush_cnt <= 1'b0;
                        state     <= ST_FLUSH;
                    end else begin
                        mac_cnt <= mac_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt) begin
                        state    <= ST_EMIT;
                        out_data <= result;
                        out_idx  <= o;
                        out_last <= (o == IDX_W'(OUTPUT_NUM - 1));
                        if ((o == '0) || (result > max_val)) begin
                            max_val <= result;
                            max_idx <= o;
                        end
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: begin
                    // out_valid is raised one cycle after the result register settles.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (o == IDX_W'(OUTPUT_NUM - 1)) begin
                            state        <= ST_LOAD;
                            argmax_valid <= 1'b1;
                            argmax_idx   <= max_idx;
                        end else begin
                            o     <= o + 1'b1;
                            acc   <= '0;
                            state <= ST_MAC;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream: default build plus a ReLU build fed
// the same stimulus, with hand-computed expected outputs per frame.
module tb_fc_layer_stream;

    localparam int IN    = 48;
    localparam int ON    = 10;
    localparam int CH    = 3;
    localparam int DW    = 12;
    localparam int WB    = 8;
    localparam int BEATS = IN / CH;
    localparam int LAT   = IN / 8 + 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic [CH*DW-1:0]         in_data;
    logic [0:IN*ON*WB-1]      w_fc;
    logic [0:ON*WB-1]         b_fc;
    logic                     out_ready;

    logic                     in_ready0, out_valid0, out_last0, argmax_valid0, busy0;
    logic signed [DW-1:0]     out_data0;
    logic [3:0]               out_idx0, argmax_idx0;
    logic                     in_ready1, out_valid1, out_last1, argmax_valid1, busy1;
    logic signed [DW-1:0]     out_data1;
    logic [3:0]               out_idx1, argmax_idx1;

    int vec [IN];
    int wt  [ON][IN];
    int bs  [ON];
    int exp_out [ON];
    int exp_arg;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_beat_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_stream dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .w_fc(w_fc), .b_fc(b_fc), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_idx(out_idx0), .out_last(out_last0),
        .argmax_valid(argmax_valid0), .argmax_idx(argmax_idx0), .busy(busy0)
    );

    fc_layer_stream #(.RELU_EN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .w_fc(w_fc), .b_fc(b_fc), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1),
        .argmax_valid(argmax_valid1), .argmax_idx(argmax_idx1), .busy(busy1)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setup(input int v, input int w, input int b);
        for (int o = 0; o < ON; o++) begin
            bs[o] = b;
            for (int i = 0; i < IN; i++) wt[o][i] = w;
        end
        for (int i = 0; i < IN; i++) vec[i] = v;
    endtask

    task automatic load_params();
        for (int o = 0; o < ON; o++) begin
            b_fc[o*WB +: WB] = bs[o][WB-1:0];
            for (int i = 0; i < IN; i++) w_fc[(o*IN+i)*WB +: WB] = wt[o][i][WB-1:0];
        end
    endtask

    task automatic send_frame();
        int guard;
        load_params();
        for (int b = 0; b < BEATS; b++) begin
            for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = vec[c*BEATS+b][DW-1:0];
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready0 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) begin
                check("in_ready_wait", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        last_beat_cyc = cyc;
    endtask

    task automatic receive_frame(input int n_out, input int stall_o, input int stall_n);
        int guard;
        int t_ref;
        int hold;
        t_ref = last_beat_cyc;
        for (int n = 0; n < n_out; n++) begin
            guard = 0;
            while (!out_valid0 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                check("out_valid_wait", 0, 1);
                return;
            end
            check("latency", cyc - t_ref, LAT);
            check("out_idx", out_idx0, n);
            check("out_last", out_last0, (n == ON-1) ? 1 : 0);
            check("out_data", out_data0, exp_out[n]);
            check("relu_data", out_data1, (exp_out[n] < 0) ? 0 : exp_out[n]);
            hold = out_data0;
            if (n == stall_o) begin
                repeat (stall_n) begin
                    @(negedge clk);
                    check("stall_data", out_data0, hold);
                    check("stall_idx", out_idx0, n);
                    check("stall_valid", out_valid0, 1);
                    check("stall_in_ready", in_ready0, 0);
                    check("stall_busy", busy0, 1);
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            t_ref = cyc;
            check("valid_drop", out_valid0, 0);
            if (n == ON-1) begin
                check("argmax_pulse", argmax_valid0, 1);
                check("argmax_idx", argmax_idx0, exp_arg);
                @(negedge clk);
                check("argmax_single", argmax_valid0, 0);
                check("idle_in_ready", in_ready0, 1);
                check("idle_busy", busy0, 0);
            end else begin
                check("argmax_quiet", argmax_valid0, 0);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready0, 1);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_out_valid"}, out_valid0, 0);
        check({tag, "_out_data"}, out_data0, 0);
        check({tag, "_out_idx"}, out_idx0, 0);
        check({tag, "_out_last"}, out_last0, 0);
        check({tag, "_argmax_valid"}, argmax_valid0, 0);
        check({tag, "_argmax_idx"}, argmax_idx0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        w_fc = '0;
        b_fc = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Baseline: 128 * 1 * 48 = 6144 -> 48; backpressure at o=3; ties -> 0.
        setup(128, 1, 0);
        for (int o = 0; o < ON; o++) exp_out[o] = 48;
        exp_arg = 0;
        send_frame();
        receive_frame(ON, 3, 5);

        // Rounding: 192 -> 2, -192 -> -1, bias -64 on zero -> 0.
        setup(0, 0, 0);
        vec[0] = 192;
        vec[1] = -192;
        wt[0][0] = 1;
        wt[2][1] = 1;
        bs[1] = -64;
        for (int o = 0; o < ON; o++) exp_out[o] = 0;
        exp_out[0] = 2;
        exp_out[2] = -1;
        exp_arg = 0;
        send_frame();
        receive_frame(ON, -1, 0);

        // Positive saturation.
        setup(2047, 127, 0);
        for (int o = 0; o < ON; o++) exp_out[o] = 2047;
        exp_arg = 0;
        send_frame();
        receive_frame(ON, -1, 0);

        // Negative saturation; the ReLU build clamps to 0.
        setup(-2048, 127, 0);
        for (int o = 0; o < ON; o++) exp_out[o] = -2048;
        exp_arg = 0;
        send_frame();
        receive_frame(ON, -1, 0);

        // Argmax: bias 127 at o=7 -> 49, bias -128 at o=3 -> 47.
        setup(128, 1, 0);
        bs[7] = 127;
        bs[3] = -128;
        for (int o = 0; o < ON; o++) exp_out[o] = 48;
        exp_out[7] = 49;
        exp_out[3] = 47;
        exp_arg = 7;
        send_frame();
        receive_frame(ON, -1, 0);

        // Equal maxima at o=2 and o=5 keep the lower index.
        setup(128, 1, 0);
        bs[2] = 127;
        bs[5] = 127;
        for (int o = 0; o < ON; o++) exp_out[o] = 48;
        exp_out[2] = 49;
        exp_out[5] = 49;
        exp_arg = 2;
        send_frame();
        receive_frame(ON, -1, 0);

        // Reset while o=4 is in MAC.
        send_frame();
        receive_frame(4, -1, 0);
        @(negedge clk);
        check("pre_reset_busy", busy0, 1);
        rst = 1'b1;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh frame after the reset.
        setup(128, 1, 0);
        bs[7] = 127;
        bs[3] = -128;
        for (int o = 0; o < ON; o++) exp_out[o] = 48;
        exp_out[7] = 49;
        exp_out[3] = 47;
        exp_arg = 7;
        send_frame();
        receive_frame(ON, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
